// File: rtl/piano_pkg.sv
// piano_pkg: note pitches, song ROMs, 7-segment glyphs and mode encoding for the piano
package piano_pkg;

    typedef enum logic [1:0] {FREE = 2'd0, LEARN = 2'd1, AUTO = 2'd2} mode_t;

    // Indexed by switch number: sw[0]=C5 ... sw[7]=C4
    localparam int NOTE_HZ [8] = '{523, 494, 440, 392, 349, 330, 294, 262};

    localparam logic [2:0] SONG_ODE [15] = '{3'd5, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6,
                                             3'd7, 3'd7, 3'd6, 3'd5, 3'd5, 3'd6, 3'd6};
    localparam logic [2:0] SONG_DRM [15] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
                                             3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    // Active-low {dp,g,f,e,d,c,b,a}, dp always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_G     = 8'hC2;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] GLYPH_NOTE [8] = '{SEG_C, SEG_B, SEG_A, SEG_G, SEG_F, SEG_E, SEG_D, SEG_C};

    function automatic logic [19:0] half_period(int clk_hz, logic [2:0] n);
        return 20'(clk_hz / (2 * NOTE_HZ[n]));
    endfunction

endpackage

// File: rtl/piano_debounce.sv
// piano_debounce: level follows the input only after DEBOUNCE_CYCLES equal samples; rise pulses on a new high level
module piano_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic rise
);
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (in == level)
                cnt <= '0;
            else if (cnt == LAST) begin
                cnt   <= '0;
                level <= in;
                rise  <= in;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/piano_top.sv
// piano_top: eight-switch piano with free play, guided learn and autoplay modes, LED guide and 4-digit display
module piano_top import piano_pkg::*; #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NOTE_TICKS      = 25_000_000,
    parameter int SCAN_DIV        = 100_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MODE,
    input  logic       MODE2,
    input  logic [7:0] sw,
    output logic       FREQ,
    output logic [7:0] Led,
    output logic [7:0] seg,
    output logic [3:0] an
);
    localparam int TW  = $clog2(NOTE_TICKS + 1);
    localparam int SCW = $clog2(SCAN_DIV + 1);
    localparam logic [19:0] HALF [8] = '{half_period(CLK_HZ, 3'd0), half_period(CLK_HZ, 3'd1),
                                         half_period(CLK_HZ, 3'd2), half_period(CLK_HZ, 3'd3),
                                         half_period(CLK_HZ, 3'd4), half_period(CLK_HZ, 3'd5),
                                         half_period(CLK_HZ, 3'd6), half_period(CLK_HZ, 3'd7)};

    logic [7:0]     sw_m, sw_s, sw_q;
    logic           mode_lvl, mode_rise, song_lvl, song_rise, song_prev;
    logic           press, song_chg, restart, advance, active, active_q;
    mode_t          mode;
    logic [3:0]     idx;
    logic [TW-1:0]  tick;
    logic [2:0]     exp_note, sw_note, note, note_q;
    logic [19:0]    cnt;
    logic [SCW-1:0] scan;
    logic [1:0]     digit;
    logic [7:0]     glyph;

    piano_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(CLK), .rst_n(RESET), .in(MODE), .level(mode_lvl), .rise(mode_rise)
    );

    piano_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_song (
        .clk(CLK), .rst_n(RESET), .in(MODE2), .level(song_lvl), .rise(song_rise)
    );

    // Lowest pitch wins: the highest set switch index overrides lower ones
    always_comb begin
        sw_note = 3'd0;
        for (int i = 0; i < 8; i++)
            if (sw_s[i]) sw_note = 3'(i);
    end

    always_comb begin
        press    = mode_rise & mode_lvl;
        song_chg = song_rise | (song_prev & ~song_lvl);
        restart  = press | song_chg;
        exp_note = song_lvl ? SONG_DRM[idx] : SONG_ODE[idx];
        note     = mode == AUTO ? exp_note : sw_note;
        active   = mode == AUTO || |sw_s;
        advance  = mode == LEARN ? sw_s[exp_note] & ~sw_q[exp_note]
                                 : mode == AUTO && tick == TW'(NOTE_TICKS - 1);
        Led      = mode == FREE ? sw_s : 8'd1 << exp_note;
        glyph    = digit == 2'd0 ? (active ? GLYPH_NOTE[note] : SEG_DASH)
                 : digit == 2'd1 ? (!active ? SEG_BLANK : note == 3'd0 ? SEG_5 : SEG_4)
                 : digit == 2'd2 ? (song_lvl ? SEG_2 : SEG_1)
                 : mode == FREE ? SEG_0 : mode == LEARN ? SEG_1 : SEG_2;
    end

    // A mode press takes priority over a same-cycle index advance
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sw_m      <= '0;
            sw_s      <= '0;
            sw_q      <= '0;
            song_prev <= 1'b0;
            mode      <= FREE;
            idx       <= '0;
            tick      <= '0;
        end else begin
            sw_m      <= sw;
            sw_s      <= sw_m;
            sw_q      <= sw_s;
            song_prev <= song_lvl;
            if (restart) begin
                if (press) mode <= mode == FREE ? LEARN : mode == LEARN ? AUTO : FREE;
                idx  <= '0;
                tick <= '0;
            end else begin
                tick <= (mode == AUTO && !advance) ? tick + 1'b1 : '0;
                if (advance) idx <= idx == 4'd14 ? 4'd0 : idx + 1'b1;
            end
        end
    end

    // A new note restarts the half-period count without disturbing the output level
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            note_q   <= '0;
            active_q <= 1'b0;
            cnt      <= '0;
            FREQ     <= 1'b0;
        end else begin
            note_q   <= note;
            active_q <= active;
            if (!active) begin
                cnt  <= '0;
                FREQ <= 1'b0;
            end else if (restart || !active_q || note != note_q)
                cnt <= '0;
            else if (cnt == HALF[note] - 20'd1) begin
                cnt  <= '0;
                FREQ <= ~FREQ;
            end else
                cnt <= cnt + 20'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan  <= '0;
            digit <= '0;
            an    <= 4'b1111;
            seg   <= 8'hFF;
        end else begin
            an  <= ~(4'd1 << digit);
            seg <= glyph;
            if (scan == SCW'(SCAN_DIV - 1)) begin
                scan  <= '0;
                digit <= digit + 2'd1;
            end else
                scan <= scan + 1'b1;
        end
    end
endmodule

// File: tb/tb_piano_top.sv
// tb_piano_top: directed self-checking bench for the piano top level at reduced clock and timing parameters
module tb_piano_top;
    logic       CLK = 1'b0, RESET = 1'b0, MODE = 1'b0, MODE2 = 1'b0;
    logic [7:0] sw = 8'd0;
    logic       FREQ;
    logic [7:0] Led, seg;
    logic [3:0] an;
    int checks = 0, errors = 0;

    localparam logic [2:0] ODE [15] = '{3'd5, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6,
                                        3'd7, 3'd7, 3'd6, 3'd5, 3'd5, 3'd6, 3'd6};
    localparam logic [2:0] DRM [15] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
                                        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    piano_top #(.CLK_HZ(1_000_000), .DEBOUNCE_CYCLES(4), .NOTE_TICKS(20), .SCAN_DIV(8)) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .MODE2(MODE2), .sw(sw),
        .FREQ(FREQ), .Led(Led), .seg(seg), .an(an)
    );

    always #5 CLK = ~CLK;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_an(input logic [3:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (an === a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_freq(input logic v, input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            @(negedge CLK);
            if (FREQ === v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_mode();
        MODE = 1'b1;
        cycles(10);
        MODE = 1'b0;
        cycles(8);
    endtask

    task automatic press_sw(input logic [2:0] i);
        sw = 8'd1 << i;
        cycles(4);
        sw = 8'd0;
        cycles(4);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        cycles(3);
        checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL reset_freq: got %b want 0", FREQ); end
        checks++; if (Led !== 8'h00) begin errors++; $display("FAIL reset_led: got %b want 00000000", Led); end
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h want ff", seg); end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_an: got %b want 1110", an); end
        checks++; if (seg !== 8'hBF) begin errors++; $display("FAIL release_dash: got %h want bf", seg); end
        @(negedge CLK);
    endtask

    task automatic test_debounce();
        bit ok;
        int len [3] = '{1, 1, 3};
        for (int g = 0; g < 3; g++) begin
            MODE = 1'b1;
            cycles(len[g]);
            MODE = 1'b0;
            cycles(6);
        end
        MODE2 = 1'b1;
        cycles(3);
        MODE2 = 1'b0;
        cycles(6);
        wait_an(4'b0111, ok);
        checks++; if (!ok || seg !== 8'hC0) begin errors++; $display("FAIL glitch_mode: seg=%h ok=%0d want c0", seg, ok); end
        wait_an(4'b1011, ok);
        checks++; if (!ok || seg !== 8'hF9) begin errors++; $display("FAIL glitch_song: seg=%h ok=%0d want f9", seg, ok); end
    endtask

    task automatic test_free_tone();
        bit ok;
        int n;
        logic v;
        sw = 8'b0000_0100;
        cycles(4);
        v = FREQ;
        wait_freq(~v, 3000, n);
        wait_freq(v, 3000, n);
        checks++; if (n !== 1136) begin errors++; $display("FAIL a4_half: got %0d want 1136", n); end
        checks++; if (Led !== 8'b0000_0100) begin errors++; $display("FAIL a4_led: got %b want 00000100", Led); end
        wait_an(4'b1110, ok);
        checks++; if (!ok || seg !== 8'h88) begin errors++; $display("FAIL a4_letter: seg=%h ok=%0d want 88", seg, ok); end
        wait_an(4'b1101, ok);
        checks++; if (!ok || seg !== 8'h99) begin errors++; $display("FAIL a4_octave: seg=%h ok=%0d want 99", seg, ok); end
        sw = 8'b1000_0001;
        cycles(4);
        v = FREQ;
        wait_freq(~v, 5000, n);
        wait_freq(v, 5000, n);
        checks++; if (n !== 1908) begin errors++; $display("FAIL c4_half: got %0d want 1908", n); end
        checks++; if (Led !== 8'b1000_0001) begin errors++; $display("FAIL c4_led: got %b want 10000001", Led); end
        wait_an(4'b1110, ok);
        checks++; if (!ok || seg !== 8'hC6) begin errors++; $display("FAIL c4_letter: seg=%h ok=%0d want c6", seg, ok); end
        wait_an(4'b1101, ok);
        checks++; if (!ok || seg !== 8'h99) begin errors++; $display("FAIL c4_octave: seg=%h ok=%0d want 99", seg, ok); end
        sw = 8'd0;
        cycles(4);
        checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL silent_freq: got %b want 0", FREQ); end
        wait_an(4'b1110, ok);
        checks++; if (!ok || seg !== 8'hBF) begin errors++; $display("FAIL silent_dash: seg=%h ok=%0d want bf", seg, ok); end
        wait_an(4'b1101, ok);
        checks++; if (!ok || seg !== 8'hFF) begin errors++; $display("FAIL silent_blank: seg=%h ok=%0d want ff", seg, ok); end
    endtask

    task automatic test_mode_press();
        bit ok;
        press_mode();
        wait_an(4'b0111, ok);
        checks++; if (!ok || seg !== 8'hF9) begin errors++; $display("FAIL learn_digit3: seg=%h ok=%0d want f9", seg, ok); end
        checks++; if (Led !== 8'b0010_0000) begin errors++; $display("FAIL learn_first: got %b want 00100000", Led); end
    endtask

    task automatic test_learn();
        bit ok;
        logic [7:0] want;
        press_sw(3'd5);
        checks++; if (Led !== 8'b0010_0000) begin errors++; $display("FAIL learn_step1: got %b want 00100000", Led); end
        press_sw(3'd5);
        checks++; if (Led !== 8'b0001_0000) begin errors++; $display("FAIL learn_step2: got %b want 00010000", Led); end
        press_sw(3'd4);
        checks++; if (Led !== 8'b0000_1000) begin errors++; $display("FAIL learn_step3: got %b want 00001000", Led); end
        sw = 8'b0000_0001;
        cycles(4);
        checks++; if (Led !== 8'b0000_1000) begin errors++; $display("FAIL learn_wrong: got %b want 00001000", Led); end
        wait_an(4'b1101, ok);
        checks++; if (!ok || seg !== 8'h92) begin errors++; $display("FAIL c5_octave: seg=%h ok=%0d want 92", seg, ok); end
        wait_an(4'b1110, ok);
        checks++; if (!ok || seg !== 8'hC6) begin errors++; $display("FAIL c5_letter: seg=%h ok=%0d want c6", seg, ok); end
        sw = 8'd0;
        cycles(4);
        checks++; if (Led !== 8'b0000_1000) begin errors++; $display("FAIL learn_hold: got %b want 00001000", Led); end
        for (int i = 3; i < 15; i++) begin
            press_sw(ODE[i]);
            want = 8'd1 << ODE[(i + 1) % 15];
            checks++; if (Led !== want) begin errors++; $display("FAIL learn_song%0d: got %b want %b", i, Led, want); end
        end
    endtask

    task automatic test_auto();
        bit ok;
        logic [7:0] want;
        MODE2 = 1'b1;
        cycles(8);
        checks++; if (Led !== 8'b1000_0000) begin errors++; $display("FAIL drm_first: got %b want 10000000", Led); end
        wait_an(4'b1011, ok);
        checks++; if (!ok || seg !== 8'hA4) begin errors++; $display("FAIL drm_digit2: seg=%h ok=%0d want a4", seg, ok); end
        MODE = 1'b1;
        cycles(10);
        MODE = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (Led !== 8'b1000_0000) break;
        end
        checks++; if (Led !== 8'b0100_0000) begin errors++; $display("FAIL auto_note1: got %b want 01000000", Led); end
        sw = 8'hFF;
        for (int k = 2; k <= 16; k++) begin
            cycles(20);
            want = 8'd1 << DRM[k % 15];
            checks++; if (Led !== want) begin errors++; $display("FAIL auto_note%0d: got %b want %b", k, Led, want); end
        end
        wait_an(4'b0111, ok);
        checks++; if (!ok || seg !== 8'hA4) begin errors++; $display("FAIL auto_digit3: seg=%h ok=%0d want a4", seg, ok); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        sw = 8'd0;
        cycles(3);
        RESET = 1'b0;
        #1;
        checks++; if (Led !== 8'h00) begin errors++; $display("FAIL mid_led: got %b want 00000000", Led); end
        checks++; if (an !== 4'b1111 || seg !== 8'hFF) begin errors++; $display("FAIL mid_display: an=%b seg=%h want 1111 ff", an, seg); end
        checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL mid_freq: got %b want 0", FREQ); end
        cycles(2);
        RESET = 1'b1;
        cycles(8);
        wait_an(4'b0111, ok);
        checks++; if (!ok || seg !== 8'hC0) begin errors++; $display("FAIL mid_mode: seg=%h ok=%0d want c0", seg, ok); end
        sw = 8'b0000_0100;
        wait_freq(1'b1, 3000, n);
        RESET = 1'b0;
        #1;
        checks++; if (n < 0 || FREQ !== 1'b0) begin errors++; $display("FAIL async_freq: got %b after %0d cycles want 0", FREQ, n); end
        sw = 8'd0;
        cycles(2);
        RESET = 1'b1;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_free_tone();
        test_mode_press();
        test_learn();
        test_auto();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
